// File: rtl/ht_code_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ht_code_packer
//  Purpose  : Packs the Huffman-tree core's serial code bursts MSB-first into
//             WORD_W-bit words. Each word is tagged with its valid-bit count
//             and an end-of-burst flag. Words are buffered in a
//             first-word-fall-through FIFO and read out via valid/ready.
//  Ports    : clk, rst_n               - clock, async active-low reset
//             code_valid, code_bit     - serial code input from the core
//             word_ready               - consumer takes the head word
//             word_valid               - FIFO non-empty
//             word_data/nbits/last     - head word fields (0 when empty)
//             fifo_level               - stored word count (0..DEPTH)
//             overflow                 - sticky: a word was dropped
//  Revision : 1.0  initial release
// ============================================================================
module ht_code_packer #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      code_valid,
    input  logic                      code_bit,
    input  logic                      word_ready,
    output logic                      word_valid,
    output logic [WORD_W-1:0]         word_data,
    output logic [$clog2(WORD_W):0]   word_nbits,
    output logic                      word_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow
);

    localparam int c_CNT_W = $clog2(WORD_W) + 1;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LVL_W = c_AW + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(WORD_W);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL  = c_LVL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]  r_sh;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_word_full;
    logic               w_push_req;
    logic [c_CNT_W-1:0] w_shamt;
    logic [WORD_W-1:0]  w_push_data;

    assign w_word_full = (r_cnt == c_FULL_CNT);

    // A full word is only pushed once the next cycle is seen, so the last
    // flag is known: a further valid bit means last=0, an idle cycle means
    // the word closes the burst.
    assign w_push_req  = code_valid ? w_word_full : (r_cnt != '0);

    // Left-justify partial words; a full word needs no shift (shamt = 0).
    assign w_shamt     = c_FULL_CNT - r_cnt;
    assign w_push_data = r_sh << w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (code_valid) begin
            if (w_word_full) begin
                r_sh  <= {{(WORD_W-1){1'b0}}, code_bit};
                r_cnt <= c_CNT_W'(1);
            end else begin
                r_sh  <= {r_sh[WORD_W-2:0], code_bit};
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else begin
            r_sh  <= '0;
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]  r_mem_data  [DEPTH];
    logic [c_CNT_W-1:0] r_mem_nbits [DEPTH];
    logic               r_mem_last  [DEPTH];

    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LVL);
    assign w_pop   = !w_empty && word_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    // Storage needs no reset: its contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= w_push_data;
            r_mem_nbits[r_wr_ptr] <= r_cnt;
            r_mem_last[r_wr_ptr]  <= !code_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign word_valid = !w_empty;
    assign word_data  = w_empty ? '0   : r_mem_data[r_rd_ptr];
    assign word_nbits = w_empty ? '0   : r_mem_nbits[r_rd_ptr];
    assign word_last  = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ht_code_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ht_code_packer
//  Purpose  : Self-checking bench for ht_code_packer. A queue-based model
//             splits each burst into words and tracks the FIFO contents;
//             every cycle all DUT outputs are compared against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ht_code_packer;

    localparam int W = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic       code_bit;
    logic       word_ready;
    logic       word_valid;
    logic [W-1:0] word_data;
    logic [$clog2(W):0] word_nbits;
    logic       word_last;
    logic [$clog2(D):0] fifo_level;
    logic       overflow;

    ht_code_packer #(.WORD_W(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code_bit   (code_bit),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_nbits (word_nbits),
        .word_last  (word_last),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        int           nbits;
        bit           last;
    } word_t;

    word_t mq[$];   // expected FIFO contents, head at index 0
    bit    cur[$];  // bits of the word currently being collected
    bit    m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input bit last);
        word_t w;
        w.data = '0;
        foreach (cur[i]) w.data[W-1-i] = cur[i];
        w.nbits = cur.size();
        w.last  = last;
        return w;
    endfunction

    // Effect of one clock edge given the inputs it samples.
    task automatic model_edge(input bit v, input bit b, input bit r);
        bit    pop;
        bit    have;
        word_t w;
        pop  = (mq.size() != 0) && r;
        have = 1'b0;
        if (v) begin
            if (cur.size() == W) begin
                w = mk(1'b0);
                have = 1'b1;
                cur.delete();
            end
            cur.push_back(b);
        end else if (cur.size() != 0) begin
            w = mk(1'b1);
            have = 1'b1;
            cur.delete();
        end
        if (pop) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < D) mq.push_back(w);
            else               m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        cur.delete();
        m_ovf = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        word_t h;
        bit    e;
        e = (mq.size() != 0);
        h.data = '0; h.nbits = 0; h.last = 1'b0;
        if (e) h = mq[0];
        check({tag, ".valid"},    32'(word_valid), 32'(e));
        check({tag, ".data"},     32'(word_data),  32'(h.data));
        check({tag, ".nbits"},    32'(word_nbits), 32'(h.nbits));
        check({tag, ".last"},     32'(word_last),  32'(h.last));
        check({tag, ".level"},    32'(fifo_level), 32'(mq.size()));
        check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},    32'(word_valid), 32'd0);
        check({tag, ".data"},     32'(word_data),  32'd0);
        check({tag, ".nbits"},    32'(word_nbits), 32'd0);
        check({tag, ".last"},     32'(word_last),  32'd0);
        check({tag, ".level"},    32'(fifo_level), 32'd0);
        check({tag, ".overflow"}, 32'(overflow),   32'd0);
    endtask

    task automatic check_head(input string tag, input logic [W-1:0] d, input int n, input bit l);
        check({tag, ".valid"}, 32'(word_valid), 32'd1);
        check({tag, ".data"},  32'(word_data),  32'(d));
        check({tag, ".nbits"}, 32'(word_nbits), 32'(n));
        check({tag, ".last"},  32'(word_last),  32'(l));
    endtask

    // Drive inputs, take one edge, then compare all outputs 1 ns later.
    task automatic step(input bit v, input bit b, input bit r);
        code_valid = v;
        code_bit   = b;
        word_ready = r;
        @(posedge clk);
        model_edge(v, b, r);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        code_bit   = 1'b0;
        word_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic burst(input logic [31:0] bits, input int n, input bit r);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], r);
    endtask

    initial begin
        logic [31:0] pat;
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_bit   = 1'b0;
        word_ready = 1'b0;
        model_clear();
        do_reset();

        // 8-bit burst, ready held high: one word, valid for one cycle.
        pat = 32'hB2;
        burst(pat, 8, 1'b1);
        check("b2.pre_valid", 32'(word_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check_head("b2", 8'hB2, 8, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("b2.post_valid", 32'(word_valid), 32'd0);

        // 3-bit burst.
        pat = 32'b110;
        burst(pat, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_head("c0", 8'hC0, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("c0.level", 32'(fifo_level), 32'd0);

        // 11-bit burst splits into a full word and a 3-bit tail.
        pat = 32'b10100101_101;
        burst(pat, 11, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("a5.level", 32'(fifo_level), 32'd2);
        check_head("a5.w0", 8'hA5, 8, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_head("a5.w1", 8'hA0, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Two 4-bit bursts separated by a single idle cycle stay separate.
        pat = 32'b1111;
        burst(pat, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        pat = 32'b0001;
        burst(pat, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("f0.level", 32'(fifo_level), 32'd2);
        check_head("f0", 8'hF0, 4, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_head("10", 8'h10, 4, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Five 1-bit bursts with no reader: fifth word dropped.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("ovf.level", 32'(fifo_level), 32'd4);
        check("ovf.flag",  32'(overflow),   32'd1);
        for (int i = 0; i < 4; i++) begin
            check_head("ovf.drain", 8'h80, 1, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        check("ovf.level_end", 32'(fifo_level), 32'd0);
        check("ovf.sticky",    32'(overflow),   32'd1);

        // Asynchronous reset mid-burst with two words queued.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        pat = 32'b10110;
        burst(pat, 5, 1'b0);
        check("mid.level", 32'(fifo_level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid.async");
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        pat = 32'b11;
        burst(pat, 2, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("mid.level2", 32'(fifo_level), 32'd1);
        check_head("mid.c0", 8'hC0, 2, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("mid.level3", 32'(fifo_level), 32'd0);

        // Randomized traffic with varying reader pressure.
        for (int ph = 0; ph < 3; ph++) begin
            int rp;
            rp = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
            do_reset();
            for (int c = 0; c < 600; c++) begin
                step(($urandom_range(99) < 75), $urandom_range(1),
                     ($urandom_range(99) < rp));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
